fetch_sequencer: RTL and testbench

// - Sequences instruction memory: owns the PC, drives the IM readAddress, and captures IM output

---
 rtl/fetch_sequencer_pkg.sv | 14 +
 rtl/fetch_sequencer_out_reg.sv | 45 ++++
 rtl/fetch_sequencer.sv | 96 +++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// State encoding is fixed so that debug probes read the same values across builds.
package fetch_sequencer_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_sequencer_out_reg.sv
// One-entry valid/ready slice holding the fetched instruction and its address.
// Priority: flush over load over accept.
module fetch_sequencer_out_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_accept,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC and fetch FSM; drives IM address and feeds decode through the output slice.
//   state     | meaning
//   ST_IDLE   | after reset, waiting for start
//   ST_FETCH  | loading one word per cycle whenever the slice is free
//   ST_HALTED | halt word seen; waiting for start to resume at the next PC
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_im_addr,
    input  logic [INSTR_W-1:0] i_im_instr,
    output logic [INSTR_W-1:0] o_instr_out,
    output logic [ADDR_W-1:0]  o_instr_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_branch_take,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_halted
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               w_load;
    logic               w_accept;
    logic               w_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Branch redirect wins over everything else, including start and halt detection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        if (i_branch_take) begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = i_branch_target;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (!w_valid || i_instr_ready) begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + ADDR_W'(1);
                        if (i_im_instr == HALT_WORD) w_state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (i_start) w_state_nxt = ST_FETCH;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_accept = w_valid && i_instr_ready;

    fetch_sequencer_out_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_accept (w_accept),
        .i_flush  (i_branch_take),
        .i_instr  (i_im_instr),
        .i_pc     (r_pc),
        .o_instr  (o_instr_out),
        .o_pc     (o_instr_pc),
        .o_valid  (w_valid)
    );

    assign o_im_addr     = r_pc;
    assign o_instr_valid = w_valid;
    assign o_halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  im_addr;
    logic [15:0] im_instr;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_take;
    logic [7:0]  branch_target;
    logic        halted;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 = idle, 1 = fetching, 2 = halted
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_word;
    int          m_wpc;
    int          m_mode;

    fetch_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .o_im_addr       (im_addr),
        .i_im_instr      (im_instr),
        .o_instr_out     (instr_out),
        .o_instr_pc      (instr_pc),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .i_branch_take   (branch_take),
        .i_branch_target (branch_target),
        .o_halted        (halted)
    );

    assign im_instr = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_valid = 1'b0;
        m_word  = 16'h0000;
        m_wpc   = 0;
        m_mode  = 0;
    endtask

    task automatic model_edge();
        if (branch_take) begin
            m_pc    = int'(branch_target);
            m_valid = 1'b0;
            m_mode  = 1;
        end else if (m_mode == 1) begin
            if (!m_valid || instr_ready) begin
                m_word  = mem[m_pc];
                m_wpc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 1) % 256;
                if (m_word == 16'hFFFF) m_mode = 2;
            end
        end else begin
            if (m_valid && instr_ready) m_valid = 1'b0;
            if (start) m_mode = 1;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, m_valid});
        check({tag, ".addr"},   {24'd0, im_addr}, m_pc);
        check({tag, ".halted"}, {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
        check({tag, ".instr"},  {16'd0, instr_out}, {16'd0, m_word});
        check({tag, ".ipc"},    {24'd0, instr_pc}, m_wpc);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic mid_reset(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, ".rst_valid"},  {31'd0, instr_valid}, 32'd0);
        check({tag, ".rst_addr"},   {24'd0, im_addr}, 32'd0);
        check({tag, ".rst_halted"}, {31'd0, halted}, 32'd0);
        compare_model(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        mem[0]   = 16'hB180;
        mem[1]   = 16'h0199;
        mem[2]   = 16'h0349;
        mem[3]   = 16'h0409;
        mem[4]   = 16'h03C9;
        mem[5]   = 16'hFFFF;
        mem[255] = 16'h0001;

        rst = 1'b0; start = 1'b0; instr_ready = 1'b0;
        branch_take = 1'b0; branch_target = 8'h00;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset.valid",  {31'd0, instr_valid}, 32'd0);
        check("reset.addr",   {24'd0, im_addr}, 32'd0);
        check("reset.halted", {31'd0, halted}, 32'd0);
        check("reset.instr",  {16'd0, instr_out}, 32'd0);
        check("reset.ipc",    {24'd0, instr_pc}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        start = 1'b1; instr_ready = 1'b1;
        step("start");
        check("entry.valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b0;
        step("seq0");
        check("seq0.instr", {16'd0, instr_out}, 32'h0000B180);
        step("seq1");
        check("seq1.instr", {16'd0, instr_out}, 32'h00000199);
        step("seq2");
        check("seq2.ipc", {24'd0, instr_pc}, 32'd2);

        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            check("bp.instr", {16'd0, instr_out}, 32'h00000349);
            check("bp.addr",  {24'd0, im_addr}, 32'd3);
        end
        instr_ready = 1'b1;
        step("bp_release");
        check("bp_release.ipc", {24'd0, instr_pc}, 32'd3);

        instr_ready = 1'b0;
        step("hold");
        branch_take = 1'b1; branch_target = 8'h40;
        step("branch");
        check("branch.valid", {31'd0, instr_valid}, 32'd0);
        check("branch.addr",  {24'd0, im_addr}, 32'h40);
        branch_take = 1'b0;
        step("branch_first");
        check("branch_first.ipc", {24'd0, instr_pc}, 32'h40);

        instr_ready = 1'b1;
        branch_take = 1'b1; branch_target = 8'h04;
        step("to4");
        branch_take = 1'b0;
        step("w4");
        step("halt");
        check("halt.instr",  {16'd0, instr_out}, 32'h0000FFFF);
        check("halt.ipc",    {24'd0, instr_pc}, 32'd5);
        check("halt.halted", {31'd0, halted}, 32'd1);
        check("halt.addr",   {24'd0, im_addr}, 32'd6);
        step("halted_accept");
        step("halted_idle");
        check("halted_idle.valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b1;
        step("resume");
        start = 1'b0;
        step("resume_first");
        check("resume_first.ipc", {24'd0, instr_pc}, 32'd6);

        branch_take = 1'b1; branch_target = 8'hFF;
        step("to_ff");
        branch_take = 1'b0;
        step("wrap_ff");
        check("wrap_ff.ipc", {24'd0, instr_pc}, 32'hFF);
        step("wrap_00");
        check("wrap_00.ipc", {24'd0, instr_pc}, 32'h00);

        mid_reset("async");
        step("post_reset_idle");
        check("post_reset_idle.addr", {24'd0, im_addr}, 32'd0);

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        for (int i = 0; i < 6; i++) mem[$urandom_range(0, 255)] = 16'hFFFF;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start         = ($urandom_range(0, 7) == 0);
            instr_ready   = ($urandom_range(0, 9) < 7);
            branch_take   = ($urandom_range(0, 9) == 0);
            branch_target = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) mid_reset("rnd");
            else step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
